// File: rtl/multiport_register_file.sv
// Parametrised NR/MW integer register file with a hardwired-zero x0, optional
// same-cycle write-to-read bypass and a per-register pending-write scoreboard.
module multiport_register_file #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     NUM_REGS  = 32,
    parameter int unsigned     ADDR_W    = $clog2(NUM_REGS),
    parameter int unsigned     NUM_READ  = 2,
    parameter int unsigned     NUM_WRITE = 1,
    parameter int unsigned     BYPASS    = 1,
    parameter int unsigned     SP_INDEX  = 2,
    parameter logic [XLEN-1:0] SP_RESET  = XLEN'(32'h0100_0000)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_READ*ADDR_W-1:0]    rd_addr,
    output logic [NUM_READ*XLEN-1:0]      rd_data,
    output logic [NUM_READ-1:0]           rd_pending,
    input  logic [NUM_WRITE-1:0]          wr_en,
    input  logic [NUM_WRITE*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0]     wr_data,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic                          any_pending
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    logic [ADDR_W-1:0]   wa [NUM_WRITE];
    logic [XLEN-1:0]     wd [NUM_WRITE];
    logic                wv [NUM_WRITE];
    logic                rsv_ok;

    // Writable/readable address: not x0 and inside the implemented range.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

    // Unpack write ports and qualify each with enable and address validity.
    for (genvar j = 0; j < int'(NUM_WRITE); j++) begin : g_wr
        assign wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
        assign wd[j] = wr_data[j*XLEN +: XLEN];
        assign wv[j] = wr_en[j] && addr_ok(wa[j]);
    end

    assign rsv_ok = rsv_en && addr_ok(rsv_addr);

    // Register and scoreboard update; later ports override earlier ones, and a
    // reservation overrides a same-cycle write clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs[ADDR_W'(k)] <= (k == SP_INDEX && k != 0) ? SP_RESET : '0;
            end
            pending <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                if (wv[j]) begin
                    regs[wa[j]]    <= wd[j];
                    pending[wa[j]] <= 1'b0;
                end
            end
            if (rsv_ok) begin
                pending[rsv_addr] <= 1'b1;
            end
        end
    end

    // Read ports: stored value, optionally overridden by the winning same-cycle write.
    for (genvar i = 0; i < int'(NUM_READ); i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [XLEN-1:0]   data;
        logic              pend;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        // Per-port data/pending selection with ascending-port bypass priority.
        always_comb begin
            data = '0;
            pend = 1'b0;
            if (addr_ok(ra)) begin
                data = regs[ra];
                pend = pending[ra];
            end
            if (BYPASS != 0) begin
                for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                    if (wv[j] && (wa[j] == ra)) begin
                        data = wd[j];
                        pend = 1'b0;
                    end
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_pending[i]           = pend;
    end

    assign any_pending = |pending;

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file (2R/2W, bypass on, 24 registers
// so that addresses 24..31 exercise the out-of-range path).
module tb_multiport_register_file;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NR   = 24;
    localparam int unsigned AW   = 5;
    localparam logic [31:0] SPR  = 32'h0100_0000;

    logic             clock;
    logic             reset;
    logic [2*AW-1:0]  rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]       rd_pending;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             any_pending;

    multiport_register_file #(
        .XLEN(XLEN), .NUM_REGS(NR), .NUM_READ(2), .NUM_WRITE(2),
        .BYPASS(1), .SP_INDEX(2), .SP_RESET(SPR)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_pending(any_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        p0;
        logic        p1;
        logic        ap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic chk_valid = 1'b0;

    // Monitor: pops one expectation for every checked cycle, mid-cycle.
    always @(negedge clock) begin
        if (chk_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: output presented with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (rd_data[31:0] !== e.d0 || rd_data[63:32] !== e.d1 ||
                    rd_pending[0] !== e.p0 || rd_pending[1] !== e.p1 ||
                    any_pending !== e.ap) begin
                    errors++;
                    $display("FAIL %s: got d0=%h d1=%h p=%b%b ap=%b, want d0=%h d1=%h p=%b%b ap=%b",
                             e.name, rd_data[31:0], rd_data[63:32], rd_pending[1], rd_pending[0],
                             any_pending, e.d0, e.d1, e.p1, e.p0, e.ap);
                end
            end
        end
    end

    task automatic setin(input logic [4:0] r0, input logic [4:0] r1,
                         input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic rv, input logic [4:0] ra);
        rd_addr  = {r1, r0};
        wr_en    = {we1, we0};
        wr_addr  = {a1, a0};
        wr_data  = {d1, d0};
        rsv_en   = rv;
        rsv_addr = ra;
    endtask

    task automatic expect_push(input string n, input logic [31:0] d0, input logic [31:0] d1,
                               input logic p0, input logic p1, input logic ap);
        exp_t e;
        e.name = n; e.d0 = d0; e.d1 = d1; e.p0 = p0; e.p1 = p1; e.ap = ap;
        sb.push_back(e);
    endtask

    task automatic tick();
        chk_valid = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic tick_nochk();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_read(input logic [4:0] r0, input logic [4:0] r1);
        setin(r0, r1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Reference model state for the random phase.
    logic [31:0] m  [32];
    logic        mp [32];

    function automatic logic ok(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < NR);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m[k]  = (k == 2) ? SPR : 32'd0;
            mp[k] = 1'b0;
        end
    endtask

    task automatic model_read(input logic [4:0] a, input logic we0, input logic [4:0] a0,
                              input logic [31:0] d0, input logic we1, input logic [4:0] a1,
                              input logic [31:0] d1, output logic [31:0] d, output logic p);
        if (we1 && ok(a1) && a1 == a) begin
            d = d1; p = 1'b0;
        end else if (we0 && ok(a0) && a0 == a) begin
            d = d0; p = 1'b0;
        end else if (!ok(a)) begin
            d = 32'd0; p = 1'b0;
        end else begin
            d = m[a]; p = mp[a];
        end
    endtask

    function automatic logic model_any();
        logic r;
        r = 1'b0;
        for (int k = 0; k < 32; k++) r = r | mp[k];
        return r;
    endfunction

    logic [4:0]  q_r0, q_r1, q_a0, q_a1, q_ra;
    logic [31:0] q_d0, q_d1, e_d0, e_d1;
    logic        q_we0, q_we1, q_rv, e_p0, e_p1, do_rst;

    initial begin
        reset = 1'b1;
        idle_read(5'd0, 5'd0);
        // Reset with a write and reservation that must be ignored.
        setin(5'd0, 5'd0, 1'b1, 5'd6, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
        tick_nochk();
        reset = 1'b0;

        // Reset values
        idle_read(5'd2, 5'd0);   expect_push("reset_sp",  SPR, 0, 0, 0, 0); tick();
        idle_read(5'd5, 5'd6);   expect_push("reset_zero", 0, 0, 0, 0, 0); tick();

        // Bypass of a same-cycle write, then stored value
        setin(5'd2, 5'd5, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        expect_push("bypass_x5", SPR, 32'hDEAD_BEEF, 0, 0, 0); tick();
        idle_read(5'd5, 5'd5);   expect_push("stored_x5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0); tick();

        // x0 ignores writes and reservations
        setin(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        expect_push("x0_write_bypass", 0, 0, 0, 0, 0); tick();
        setin(5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        expect_push("x0_reserve", 0, 32'hDEAD_BEEF, 0, 0, 0); tick();
        idle_read(5'd0, 5'd0);   expect_push("x0_after", 0, 0, 0, 0, 0); tick();

        // Write collision: highest port wins for bypass and storage
        setin(5'd7, 5'd5, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0, 5'd0);
        expect_push("collide_bypass", 32'd2, 32'hDEAD_BEEF, 0, 0, 0); tick();
        idle_read(5'd7, 5'd7);   expect_push("collide_stored", 32'd2, 32'd2, 0, 0, 0); tick();

        // Scoreboard sequence on x9
        setin(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        expect_push("rsv_x9_same", 0, 0, 0, 0, 0); tick();
        idle_read(5'd9, 5'd0);   expect_push("rsv_x9_next", 0, 0, 1, 0, 1); tick();
        setin(5'd9, 5'd9, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        expect_push("wr_x9_bypass", 32'h55, 32'h55, 0, 0, 1); tick();
        idle_read(5'd9, 5'd0);   expect_push("wr_x9_cleared", 32'h55, 0, 0, 0, 0); tick();
        setin(5'd9, 5'd0, 1'b1, 5'd9, 32'h66, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        expect_push("rsv_wr_same", 32'h66, 0, 0, 0, 0); tick();
        idle_read(5'd9, 5'd9);   expect_push("rsv_wins", 32'h66, 32'h66, 1, 1, 1); tick();
        setin(5'd0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        expect_push("rsv_again", 0, 32'h66, 0, 1, 1); tick();
        setin(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0);
        expect_push("wr_port1_x9", 32'h77, 0, 0, 0, 1); tick();
        idle_read(5'd9, 5'd0);   expect_push("x9_final", 32'h77, 0, 0, 0, 0); tick();

        // Out-of-range addresses and the highest valid register
        setin(5'd30, 5'd23, 1'b1, 5'd30, 32'hAAAA, 1'b1, 5'd23, 32'h23, 1'b1, 5'd30);
        expect_push("oor_bypass", 0, 32'h23, 0, 0, 0); tick();
        idle_read(5'd30, 5'd23); expect_push("oor_stored", 0, 32'h23, 0, 0, 0); tick();

        // Reserve x3 / write x4, then reset discards everything
        setin(5'd3, 5'd4, 1'b1, 5'd4, 32'h12, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        expect_push("pre_reset_same", 0, 32'h12, 0, 0, 0); tick();
        idle_read(5'd3, 5'd4);   expect_push("pre_reset_next", 0, 32'h12, 1, 0, 1); tick();
        reset = 1'b1;
        setin(5'd4, 5'd3, 1'b1, 5'd4, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
        tick_nochk();
        reset = 1'b0;
        idle_read(5'd4, 5'd2);   expect_push("post_reset_a", 0, SPR, 0, 0, 0); tick();
        idle_read(5'd3, 5'd7);   expect_push("post_reset_b", 0, 0, 0, 0, 0); tick();

        // Random traffic against the reference model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            do_rst = ($urandom_range(0, 199) == 0);
            q_r0 = 5'($urandom_range(0, 31)); q_r1 = 5'($urandom_range(0, 31));
            q_a0 = 5'($urandom_range(0, 31)); q_a1 = 5'($urandom_range(0, 31));
            q_ra = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) q_a1 = q_a0;
            if ($urandom_range(0, 2) == 0) q_r0 = q_a1;
            q_d0 = $urandom; q_d1 = $urandom;
            q_we0 = 1'($urandom_range(0, 1)); q_we1 = 1'($urandom_range(0, 1));
            q_rv = 1'($urandom_range(0, 1));
            setin(q_r0, q_r1, q_we0, q_a0, q_d0, q_we1, q_a1, q_d1, q_rv, q_ra);
            reset = do_rst;
            if (do_rst) begin
                tick_nochk();
                model_reset();
            end else begin
                model_read(q_r0, q_we0, q_a0, q_d0, q_we1, q_a1, q_d1, e_d0, e_p0);
                model_read(q_r1, q_we0, q_a0, q_d0, q_we1, q_a1, q_d1, e_d1, e_p1);
                expect_push("random", e_d0, e_d1, e_p0, e_p1, model_any());
                tick();
                if (q_we0 && ok(q_a0)) begin m[q_a0] = q_d0; mp[q_a0] = 1'b0; end
                if (q_we1 && ok(q_a1)) begin m[q_a1] = q_d1; mp[q_a1] = 1'b0; end
                if (q_rv && ok(q_ra)) mp[q_ra] = 1'b1;
            end
        end
        reset = 1'b0;
        idle_read(5'd0, 5'd0);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
